// File: rtl/dct_post_norm_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : dct_post_norm_if
// Brief    : Avalon-ST style complex stream with frame-length sideband.
// Revision : 1.0
// =============================================================================
interface dct_post_norm_if #(
    parameter int W = 16
) ();
    logic                valid;
    logic                ready;
    logic [1:0]          error;
    logic                sop;
    logic                eop;
    logic signed [W-1:0] data_real;
    logic signed [W-1:0] data_imag;
    logic [11:0]         fftpts;

    modport master (
        output valid, error, sop, eop, data_real, data_imag, fftpts,
        input  ready
    );

    modport slave (
        input  valid, error, sop, eop, data_real, data_imag, fftpts,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/dct_post_norm.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : dct_post_norm
// Brief    : Orthonormal DCT bin weighting with framing checks, 2-stage pipe.
//            Define DCT_POST_NORM_ROUND_EN for round-half-up (default: floor).
// Revision : 1.0
// =============================================================================
module dct_post_norm #(
    parameter int wDataIn  = 16,
    parameter int wDataOut = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n_sync,
    dct_post_norm_if.slave    sink,
    dct_post_norm_if.master   source
);

    localparam int C_PW = wDataIn + 16;
    localparam int C_AW = C_PW + 1;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_IN_FRAME = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] k_q, k_d;
    logic [11:0] n_q, n_d;
    logic [3:0]  l_q, l_d;

    logic                    s1_valid_q, s1_valid_d;
    logic signed [C_PW-1:0]  s1_p_re_q, s1_p_re_d;
    logic signed [C_PW-1:0]  s1_p_im_q, s1_p_im_d;
    logic [2:0]              s1_m_q, s1_m_d;
    logic                    s1_sop_q, s1_sop_d;
    logic                    s1_eop_q, s1_eop_d;
    logic [1:0]              s1_err_q, s1_err_d;
    logic [11:0]             s1_n_q, s1_n_d;

    logic                      s2_valid_q, s2_valid_d;
    logic signed [wDataOut-1:0] s2_re_q, s2_re_d;
    logic signed [wDataOut-1:0] s2_im_q, s2_im_d;
    logic                      s2_sop_q, s2_sop_d;
    logic                      s2_eop_q, s2_eop_d;
    logic [1:0]                s2_err_q, s2_err_d;
    logic [11:0]               s2_n_q, s2_n_d;

    logic        w_en;
    logic        w_fire;
    logic        w_keep;
    logic        w_last;
    logic        w_ferr;
    logic [11:0] w_k;
    logic [11:0] w_n;
    logic [3:0]  w_l;
    logic [3:0]  w_x2;
    logic [15:0] w_gain;
    logic signed [C_PW-1:0] w_din_re;
    logic signed [C_PW-1:0] w_din_im;
    logic signed [C_PW-1:0] w_gain_x;

    function automatic logic [3:0] msb_idx(input logic [11:0] v);
        msb_idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) msb_idx = 4'(i);
        end
    endfunction

    // Shift by 15+m (optionally rounded), then clamp to the output range.
    function automatic logic signed [wDataOut-1:0] norm_sat(
        input logic signed [C_PW-1:0] p,
        input logic [2:0]             m
    );
        logic signed [C_AW-1:0] acc;
        logic [4:0]             sh;
        sh  = 5'd15 + {2'b00, m};
        acc = {p[C_PW-1], p};
`ifdef DCT_POST_NORM_ROUND_EN
        acc = acc + (C_AW'(1) <<< (sh - 5'd1));
`else
        acc = acc + C_AW'(0);
`endif
        acc = acc >>> sh;
        if ((&acc[C_AW-1:wDataOut-1]) || (~|acc[C_AW-1:wDataOut-1])) begin
            norm_sat = acc[wDataOut-1:0];
        end else if (acc[C_AW-1]) begin
            norm_sat = {1'b1, {(wDataOut-1){1'b0}}};
        end else begin
            norm_sat = {1'b0, {(wDataOut-1){1'b1}}};
        end
    endfunction

    assign w_en       = ~s2_valid_q | source.ready;
    assign w_fire     = sink.valid & w_en;
    assign sink.ready = w_en;

    // Frame tracker: a sop beat always restarts at k=0 with a freshly latched N.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        l_d     = l_q;
        w_keep  = 1'b0;
        w_last  = 1'b0;
        w_ferr  = 1'b0;
        w_k     = k_q;
        w_n     = n_q;
        w_l     = l_q;
        if (w_fire) begin
            if (sink.sop) begin
                w_k    = 12'd0;
                w_n    = sink.fftpts;
                w_l    = msb_idx(sink.fftpts);
                w_keep = 1'b1;
                w_ferr = (state_q == S_IN_FRAME);
            end else if (state_q == S_IN_FRAME) begin
                w_keep = 1'b1;
            end
            if (w_keep) begin
                w_last = (w_k == (w_n - 12'd1));
                n_d    = w_n;
                l_d    = w_l;
                if (sink.eop || w_last) begin
                    w_ferr  = w_ferr | (sink.eop != w_last);
                    state_d = S_IDLE;
                    k_d     = 12'd0;
                end else begin
                    state_d = S_IN_FRAME;
                    k_d     = w_k + 12'd1;
                end
            end
        end
    end

    // Gain exponent in half-steps: L for the DC bin, L-1 for the rest.
    assign w_x2     = (w_k == 12'd0) ? w_l : (w_l - 4'd1);
    assign w_gain   = w_x2[0] ? 16'd23170 : 16'd32768;
    assign w_din_re = {{16{sink.data_real[wDataIn-1]}}, sink.data_real};
    assign w_din_im = {{16{sink.data_imag[wDataIn-1]}}, sink.data_imag};
    assign w_gain_x = {{(C_PW-16){1'b0}}, w_gain};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p_re_d  = s1_p_re_q;
        s1_p_im_d  = s1_p_im_q;
        s1_m_d     = s1_m_q;
        s1_sop_d   = s1_sop_q;
        s1_eop_d   = s1_eop_q;
        s1_err_d   = s1_err_q;
        s1_n_d     = s1_n_q;
        if (w_en) begin
            s1_valid_d = w_fire & w_keep;
            s1_p_re_d  = w_din_re * w_gain_x;
            s1_p_im_d  = w_din_im * w_gain_x;
            s1_m_d     = w_x2[3:1];
            s1_sop_d   = sink.sop | (w_k == 12'd0);
            s1_eop_d   = sink.eop;
            s1_err_d   = sink.error | {1'b0, w_ferr};
            s1_n_d     = w_n;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_re_d    = s2_re_q;
        s2_im_d    = s2_im_q;
        s2_sop_d   = s2_sop_q;
        s2_eop_d   = s2_eop_q;
        s2_err_d   = s2_err_q;
        s2_n_d     = s2_n_q;
        if (w_en) begin
            s2_valid_d = s1_valid_q;
            s2_re_d    = norm_sat(s1_p_re_q, s1_m_q);
            s2_im_d    = norm_sat(s1_p_im_q, s1_m_q);
            s2_sop_d   = s1_sop_q;
            s2_eop_d   = s1_eop_q;
            s2_err_d   = s1_err_q;
            s2_n_d     = s1_n_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            n_q        <= '0;
            l_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_p_re_q  <= '0;
            s1_p_im_q  <= '0;
            s1_m_q     <= '0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_err_q   <= '0;
            s1_n_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
            s2_sop_q   <= 1'b0;
            s2_eop_q   <= 1'b0;
            s2_err_q   <= '0;
            s2_n_q     <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            n_q        <= n_d;
            l_q        <= l_d;
            s1_valid_q <= s1_valid_d;
            s1_p_re_q  <= s1_p_re_d;
            s1_p_im_q  <= s1_p_im_d;
            s1_m_q     <= s1_m_d;
            s1_sop_q   <= s1_sop_d;
            s1_eop_q   <= s1_eop_d;
            s1_err_q   <= s1_err_d;
            s1_n_q     <= s1_n_d;
            s2_valid_q <= s2_valid_d;
            s2_re_q    <= s2_re_d;
            s2_im_q    <= s2_im_d;
            s2_sop_q   <= s2_sop_d;
            s2_eop_q   <= s2_eop_d;
            s2_err_q   <= s2_err_d;
            s2_n_q     <= s2_n_d;
        end
    end

    assign source.valid     = s2_valid_q;
    assign source.data_real = s2_re_q;
    assign source.data_imag = s2_im_q;
    assign source.sop       = s2_sop_q;
    assign source.eop       = s2_eop_q;
    assign source.error     = s2_err_q;
    assign source.fftpts    = s2_n_q;

endmodule
`default_nettype wire

// File: tb/tb_dct_post_norm.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_dct_post_norm
// Brief    : Directed self-checking bench for dct_post_norm (16- and 8-bit out).
// Revision : 1.0
// =============================================================================
module tb_dct_post_norm;

`ifdef DCT_POST_NORM_ROUND_EN
    localparam int C_R = 354;
`else
    localparam int C_R = 353;
`endif

    logic clk = 1'b0;
    logic rst_n_sync = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_post_norm_if #(.W(16)) snk ();
    dct_post_norm_if #(.W(16)) src ();
    dct_post_norm_if #(.W(16)) snk8 ();
    dct_post_norm_if #(.W(8))  src8 ();

    dct_post_norm #(.wDataIn(16), .wDataOut(16)) dut (
        .clk(clk), .rst_n_sync(rst_n_sync), .sink(snk.slave), .source(src.master));

    dct_post_norm #(.wDataIn(16), .wDataOut(8)) dut8 (
        .clk(clk), .rst_n_sync(rst_n_sync), .sink(snk8.slave), .source(src8.master));

    // The 8-bit instance sees exactly the beats the 16-bit instance accepts.
    assign snk8.valid     = snk.valid & snk.ready;
    assign snk8.error     = snk.error;
    assign snk8.sop       = snk.sop;
    assign snk8.eop       = snk.eop;
    assign snk8.data_real = snk.data_real;
    assign snk8.data_imag = snk.data_imag;
    assign snk8.fftpts    = snk.fftpts;
    assign src8.ready     = 1'b1;

    typedef struct {
        int re; int im; int sop; int eop; int err; int n; int cyc;
    } beat_t;
    beat_t q16[$];
    beat_t q8[$];

    always @(negedge clk) begin
        if (src.valid && src.ready)
            q16.push_back('{re: int'(src.data_real), im: int'(src.data_imag),
                            sop: int'(src.sop), eop: int'(src.eop),
                            err: int'(src.error), n: int'(src.fftpts), cyc: cyc});
        if (src8.valid)
            q8.push_back('{re: int'(src8.data_real), im: int'(src8.data_imag),
                           sop: int'(src8.sop), eop: int'(src8.eop),
                           err: int'(src8.error), n: int'(src8.fftpts), cyc: cyc});
    end

    task automatic drive_idle();
        snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0; snk.error = 2'b00;
        snk.data_real = '0; snk.data_imag = '0; snk.fftpts = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat is taken.
    task automatic send(input bit sop, input bit eop, input int re, input int im,
                        input int n, input logic [1:0] err);
        bit ok = 1'b0;
        snk.valid = 1'b1; snk.sop = sop; snk.eop = eop; snk.error = err;
        snk.data_real = 16'(re); snk.data_imag = 16'(im); snk.fftpts = 12'(n);
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = snk.ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout sink_ready stayed %0b, required 1", snk.ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (snk.ready !== 1'b1) begin miscompares++; $display("FAIL rst_sink_ready got %0b want 1", snk.ready); end
        vectors++;
        if (src.valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", src.valid); end
        vectors++;
        if (src.data_real !== 16'sd0 || src.data_imag !== 16'sd0) begin
            miscompares++; $display("FAIL rst_data got %0d/%0d want 0/0", src.data_real, src.data_imag); end
        vectors++;
        if (src.sop !== 1'b0 || src.eop !== 1'b0 || src.error !== 2'b00 || src.fftpts !== 12'd0) begin
            miscompares++; $display("FAIL rst_side got sop%0b eop%0b err%0d n%0d want all 0",
                                    src.sop, src.eop, src.error, src.fftpts); end
        @(posedge clk); #1;
        rst_n_sync = 1'b1;
    endtask

    task automatic test_n8();
        int t0;
        q16.delete();
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < 8; k++) send(k == 0, k == 7, 1000, -1000, 8, 2'b00);
        drive_idle();
        repeat (6) @(posedge clk); #1;
        vectors++;
        if (q16.size() != 8) begin miscompares++; $display("FAIL n8_count got %0d want 8", q16.size()); end
        for (int i = 0; i < 8 && i < q16.size(); i++) begin
            vectors++;
            if (q16[i].re != (i == 0 ? C_R : 500) || q16[i].im != (i == 0 ? -354 : -500)) begin
                miscompares++; $display("FAIL n8_bin%0d_data got %0d/%0d want %0d/%0d", i, q16[i].re,
                                        q16[i].im, (i == 0 ? C_R : 500), (i == 0 ? -354 : -500)); end
            vectors++;
            if (q16[i].sop != (i == 0) || q16[i].eop != (i == 7) || q16[i].n != 8 || q16[i].err != 0) begin
                miscompares++; $display("FAIL n8_bin%0d_side got sop%0d eop%0d n%0d err%0d", i,
                                        q16[i].sop, q16[i].eop, q16[i].n, q16[i].err); end
        end
        if (q16.size() > 0) begin
            vectors++;
            if (q16[0].cyc - t0 != 2) begin
                miscompares++; $display("FAIL n8_latency got %0d want 2", q16[0].cyc - t0); end
        end
    endtask

    task automatic test_back_to_back();
        int er, ei, j;
        q16.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) send(k == 0, k == 15, 1000, -1000, 16, 2'b00);
        for (int k = 0; k < 8; k++)  send(k == 0, k == 7, 1000, -1000, 8, 2'b00);
        drive_idle();
        repeat (6) @(posedge clk); #1;
        vectors++;
        if (q16.size() != 24) begin miscompares++; $display("FAIL b2b_count got %0d want 24", q16.size()); end
        for (int i = 0; i < 24 && i < q16.size(); i++) begin
            j  = (i < 16) ? i : i - 16;
            if (i < 16) begin er = (j == 0) ? 250 : C_R;  ei = (j == 0) ? -250 : -354; end
            else        begin er = (j == 0) ? C_R : 500;  ei = (j == 0) ? -354 : -500; end
            vectors++;
            if (q16[i].re != er || q16[i].im != ei || q16[i].n != (i < 16 ? 16 : 8) || q16[i].sop != (j == 0)) begin
                miscompares++; $display("FAIL b2b_beat%0d got %0d/%0d n%0d sop%0d want %0d/%0d n%0d sop%0d",
                                        i, q16[i].re, q16[i].im, q16[i].n, q16[i].sop, er, ei,
                                        (i < 16 ? 16 : 8), (j == 0)); end
            if (i > 0) begin
                vectors++;
                if (q16[i].cyc != q16[i-1].cyc + 1) begin
                    miscompares++; $display("FAIL b2b_gap beat%0d cycle delta %0d want 1", i,
                                            q16[i].cyc - q16[i-1].cyc); end
            end
        end
    endtask

    task automatic test_backpressure();
        int h_re, h_im, h_sop, h_eop;
        q16.delete();
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 8; k++) send(k == 0, k == 7, 200 * k, -2 * k, 8, 2'b00);
                drive_idle();
            end
            begin
                repeat (4) @(posedge clk); #1;
                src.ready = 1'b0;
                @(negedge clk);
                vectors++;
                if (snk.ready !== 1'b0 || src.valid !== 1'b1) begin
                    miscompares++; $display("FAIL bp_stall got sink_ready%0b valid%0b want 0/1",
                                            snk.ready, src.valid); end
                h_re = int'(src.data_real); h_im = int'(src.data_imag);
                h_sop = int'(src.sop); h_eop = int'(src.eop);
                vectors++;
                if (h_re != 200 || h_im != -2) begin
                    miscompares++; $display("FAIL bp_held_beat got %0d/%0d want 200/-2", h_re, h_im); end
                repeat (4) begin
                    @(negedge clk);
                    vectors++;
                    if (int'(src.data_real) != h_re || int'(src.data_imag) != h_im || src.valid !== 1'b1 ||
                        int'(src.sop) != h_sop || int'(src.eop) != h_eop) begin
                        miscompares++; $display("FAIL bp_stable got %0d/%0d v%0b want %0d/%0d v1",
                                                src.data_real, src.data_imag, src.valid, h_re, h_im); end
                end
                @(posedge clk); #1;
                src.ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk); #1;
        vectors++;
        if (q16.size() != 8) begin miscompares++; $display("FAIL bp_count got %0d want 8", q16.size()); end
        for (int i = 0; i < 8 && i < q16.size(); i++) begin
            vectors++;
            if (q16[i].re != 100 * i || q16[i].im != -i || q16[i].sop != (i == 0) || q16[i].eop != (i == 7)) begin
                miscompares++; $display("FAIL bp_beat%0d got %0d/%0d sop%0d eop%0d want %0d/%0d", i,
                                        q16[i].re, q16[i].im, q16[i].sop, q16[i].eop, 100 * i, -i); end
        end
    endtask

    task automatic test_framing();
        int ee;
        q16.delete();
        @(posedge clk); #1;
        send(1'b0, 1'b0, 77, 77, 8, 2'b00);
        send(1'b0, 1'b0, 77, 77, 8, 2'b00);
        for (int k = 0; k < 6; k++) send(k == 0, k == 5, 0, 0, 8, 2'b00);
        for (int k = 0; k < 8; k++) send(k == 0, k == 7, 0, 0, 8, (k == 3) ? 2'b10 : 2'b00);
        drive_idle();
        repeat (6) @(posedge clk); #1;
        vectors++;
        if (q16.size() != 14) begin miscompares++; $display("FAIL frm_count got %0d want 14", q16.size()); end
        for (int i = 0; i < 14 && i < q16.size(); i++) begin
            if (i < 6) ee = (i == 5) ? 1 : 0;
            else       ee = (i == 9) ? 2 : 0;
            vectors++;
            if (q16[i].err != ee || q16[i].sop != (i == 0 || i == 6) || q16[i].eop != (i == 5 || i == 13) ||
                q16[i].re != 0) begin
                miscompares++; $display("FAIL frm_beat%0d got err%0d sop%0d eop%0d re%0d want err%0d", i,
                                        q16[i].err, q16[i].sop, q16[i].eop, q16[i].re, ee); end
        end
    endtask

    task automatic test_saturation();
        int dre[8] = '{32767, 32767, -32768, 0, 0, 0, 0, 0};
        int dim[8] = '{0, -32768, 32767, 0, 0, 0, 0, 0};
        int xre[8] = '{127, 127, -128, 0, 0, 0, 0, 0};
        int xim[8] = '{0, -128, 127, 0, 0, 0, 0, 0};
        q8.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) send(k == 0, k == 7, dre[k], dim[k], 8, 2'b00);
        drive_idle();
        repeat (6) @(posedge clk); #1;
        vectors++;
        if (q8.size() != 8) begin miscompares++; $display("FAIL sat_count got %0d want 8", q8.size()); end
        for (int i = 0; i < 8 && i < q8.size(); i++) begin
            vectors++;
            if (q8[i].re != xre[i] || q8[i].im != xim[i]) begin
                miscompares++; $display("FAIL sat_bin%0d got %0d/%0d want %0d/%0d", i, q8[i].re, q8[i].im,
                                        xre[i], xim[i]); end
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) send(k == 0, 1'b0, 1000, -1000, 16, 2'b00);
        snk.valid = 1'b1; snk.sop = 1'b0; snk.data_real = 16'sd1000; snk.data_imag = -16'sd1000;
        rst_n_sync = 1'b0;
        #1;
        vectors++;
        if (snk.ready !== 1'b1 || src.valid !== 1'b0) begin
            miscompares++; $display("FAIL mrst_handshake got ready%0b valid%0b want 1/0", snk.ready, src.valid); end
        vectors++;
        if (src.data_real !== 16'sd0 || src.sop !== 1'b0 || src.fftpts !== 12'd0) begin
            miscompares++; $display("FAIL mrst_outputs got %0d sop%0b n%0d want 0", src.data_real, src.sop,
                                    src.fftpts); end
        repeat (2) @(posedge clk); #1;
        drive_idle();
        q16.delete();
        rst_n_sync = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 1'b0, 1000, -1000, 16, 2'b00);
        send(1'b0, 1'b0, 1000, -1000, 16, 2'b00);
        for (int k = 0; k < 8; k++) send(k == 0, k == 7, 1000, -1000, 8, 2'b00);
        drive_idle();
        repeat (6) @(posedge clk); #1;
        vectors++;
        if (q16.size() != 8) begin miscompares++; $display("FAIL mrst_count got %0d want 8", q16.size()); end
        for (int i = 0; i < 8 && i < q16.size(); i++) begin
            vectors++;
            if (q16[i].re != (i == 0 ? C_R : 500) || q16[i].n != 8 || q16[i].sop != (i == 0)) begin
                miscompares++; $display("FAIL mrst_bin%0d got %0d n%0d sop%0d want %0d n8", i, q16[i].re,
                                        q16[i].n, q16[i].sop, (i == 0 ? C_R : 500)); end
        end
    endtask

    initial begin
        drive_idle();
        src.ready  = 1'b1;
        rst_n_sync = 1'b0;
        repeat (2) @(posedge clk); #1;
        test_reset();
        test_n8();
        test_back_to_back();
        test_backpressure();
        test_framing();
        test_saturation();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct_post_norm.md
Name: dct_post_norm

Overview:
- Output normalisation stage that sits directly downstream of the DCT core (preFFT reorder -> FFT -> vector rotation).
- Applies the orthonormal DCT weight to each bin of a frame: w(0)=1/sqrt(N), w(k>0)=sqrt(2/N).
- Tracks frame position, checks sop/eop framing, and re-emits an Avalon-ST stream with fftpts_out.
- Two-stage pipeline with full ready/valid backpressure.

Parameters:
- wDataIn, 16, signed width of sink_real/sink_imag.
- wDataOut, 16, signed width of source_real/source_imag; results saturate to this width.

Ports:
- clk  in  1  clock.
- rst_n_sync  in  1  reset; asynchronous, active-low.
- sink_valid  in  1  input beat valid.
- sink_ready  out  1  input beat accepted when sink_valid & sink_ready.
- sink_error  in  2  upstream error, passed through.
- sink_sop  in  1  first bin of frame.
- sink_eop  in  1  last bin of frame.
- sink_real  in  wDataIn  DCT bin, real part, signed.
- sink_imag  in  wDataIn  DCT bin, imag part, signed.
- fftpts_in  in  12  frame length N (power of 2, 8..2048); sampled on the sop beat.
- source_valid  out  1  output beat valid.
- source_ready  in  1  downstream ready.
- source_error  out  2  sink_error OR {1'b0, frame_err}.
- source_sop  out  1  first output bin.
- source_eop  out  1  last output bin.
- source_real  out  wDataOut  normalised real part.
- source_imag  out  wDataOut  normalised imag part.
- fftpts_out  out  12  N latched for the frame, aligned with the data.

Behaviour:
- Reset: all outputs 0, except sink_ready=1. Pipeline valids 0, state IDLE, k=0, latched N=0.
- Pipeline enable: en = ~s2_valid | source_ready. sink_ready = en. Stage 1 (multiply) and stage 2 (shift/round/saturate) both advance on en.
- Latency: 2 cycles from accepted beat to source_valid when source_ready=1. Sustains 1 beat/cycle. No beat is lost or duplicated under any ready pattern.
- Output stability: while source_valid=1 and source_ready=0, all source_* outputs are held stable.
- FSM IDLE:
  - Accepted beat with sop: latch N=fftpts_in and L=log2(N) (index of the highest set bit); set k=0; go to IN_FRAME (stay IDLE if eop is also set and N=1).
  - Accepted beat without sop: consumed and dropped, no output.
- FSM IN_FRAME:
  - Each accepted beat increments k.
  - eop with k==N-1: normal frame end; go to IDLE.
  - eop with k!=N-1: frame_err=1 on that beat; go to IDLE.
  - k==N-1 without eop: frame_err=1 on that beat; go to IDLE.
  - sop while IN_FRAME: frame_err=1 on that beat; restart frame (relatch N, k=0).
- Gain exponent: x = L/2 for k==0, x = (L-1)/2 for k>0. Write x = m + h/2 with h in {0,1}.
- Gain constant: G = 23170 (round(2^15/sqrt2)) if h=1, else 32768.
- Stage 1: p = d*G, signed (wDataIn+16)-bit product, computed for real and imag independently.
- Stage 2: y = p >>> (15+m), arithmetic shift, rounded per Optional Feature, then saturated to [-2^(wDataOut-1), 2^(wDataOut-1)-1].
- Sideband: sop/eop/error/fftpts_out travel with the data through both stages. source_sop is forced on the k==0 beat.
- Reset mid-frame: pipeline flushed immediately; the next frame needs a fresh sop.

Optional Feature:
- Macro DCT_POST_NORM_ROUND_EN.
- Defined: round half up. Add 2^(14+m) before the shift.
- Undefined: truncate (floor) toward negative infinity.
- Saturation applies in both builds.

Test Plan:
- N=8, 8 beats real=1000, imag=-1000, source_ready=1 -> with rounding: bin0 real=354, imag=-354; bins1..7 real=500, imag=-500. Without rounding, bin0 real=353. sop on beat 0, eop on beat 7, fftpts_out=8, latency 2 cycles.
- N=16, real=1000 -> bin0=250, bins1..15=354 (rounding build). Back-to-back with an N=8 frame -> N relatched on the sop, no bubble.
- Backpressure: N=8 stream, source_ready low for 5 cycles mid-frame -> sink_ready drops within 1 cycle; outputs held stable; all 8 bins delivered in order, none lost or duplicated.
- Framing: N=8, eop on 6th beat -> source_error=2'b01 on that beat; then sop+8 beats -> clean frame with error=0. Beats before any sop -> no output.
- Saturation: wDataIn=16, wDataOut=8, N=8, bin1=32767 -> 16383.5 saturates to 127; -32768 -> -128.
- Reset: assert rst_n_sync at beat 4 of an N=16 frame -> outputs 0 and sink_ready=1 immediately; after release, the new frame outputs correctly with no stale beats.
